// File: rtl/pe_scatter_if.sv
// Handshake bundle for pe_scatter: addressed word stream in, parallel frame out.
// master = source/consumer side (testbench or upstream), slave = the scatter buffer.
interface pe_scatter_if #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3
);
  localparam int N_OUT = 2 ** SEL_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_WIDTH-1:0] in_sel;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data [N_OUT];
  logic [N_OUT-1:0]     out_mask;

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/pe_scatter.sv
// 1-to-N scatter buffer: fills N lanes from an addressed word stream, then presents the frame.
// Optional macro PE_SCATTER_COLLIDE_EN: first write wins per lane, sticky collide flag output.
module pe_scatter #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  pe_scatter_if.slave  bus
`ifdef PE_SCATTER_COLLIDE_EN
  ,
  output logic         collide
`endif
);
  localparam int N_OUT = 2 ** SEL_WIDTH;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] data_reg [N_OUT];
  logic [N_OUT-1:0] mask_reg;
  logic [N_OUT-1:0] mask_next;
  logic [N_OUT-1:0] sel_onehot;
  logic             accept;
  logic             release_frame;
  logic             close_frame;

  // Reset gates in_ready so nothing is taken while rst is held.
  assign bus.in_ready  = (state_reg == ST_FILL) && !rst;
  assign bus.out_valid = (state_reg == ST_HOLD);
  assign bus.out_mask  = mask_reg;

  assign accept        = bus.in_valid && bus.in_ready;
  assign release_frame = bus.out_valid && bus.out_ready;

  always_comb begin
    sel_onehot = '0;
    if (accept) begin
      sel_onehot = N_OUT'(1) << bus.in_sel;
    end
    mask_next   = mask_reg | sel_onehot;
    close_frame = accept && (bus.in_last || (&mask_next));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL: if (close_frame)   state_next = ST_HOLD;
      ST_HOLD: if (release_frame) state_next = ST_FILL;
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FILL;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (release_frame) begin
        mask_reg <= '0;
      end else begin
        mask_reg <= mask_next;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      logic lane_wr;
`ifdef PE_SCATTER_COLLIDE_EN
      assign lane_wr = sel_onehot[gi] && !mask_reg[gi];
`else
      assign lane_wr = sel_onehot[gi];
`endif
      always_ff @(posedge clk) begin
        if (rst || release_frame) begin
          data_reg[gi] <= '0;
        end else if (lane_wr) begin
          data_reg[gi] <= bus.in_data;
        end
      end
      assign bus.out_data[gi] = data_reg[gi];
    end
  endgenerate

`ifdef PE_SCATTER_COLLIDE_EN
  logic collide_reg;
  // A hit on an already-set lane is a collision; the flag only clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      collide_reg <= 1'b0;
    end else if ((|(sel_onehot & mask_reg))) begin
      collide_reg <= 1'b1;
    end
  end
  assign collide = collide_reg;
`endif

endmodule

// File: tb/tb_pe_scatter.sv
// Directed self-checking bench for pe_scatter; one task per scenario.
// Honours PE_SCATTER_COLLIDE_EN when the DUT is built with it.
`timescale 1ns/1ps
module tb_pe_scatter;
  localparam int WIDTH = 8;
  localparam int SEL_WIDTH = 3;
  localparam int N_OUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_data [N_OUT];

  pe_scatter_if #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) bus ();

`ifdef PE_SCATTER_COLLIDE_EN
  logic collide;
  pe_scatter #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .collide(collide));
`else
  pe_scatter #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  // Present one word and hold it until accepted (bounded), leaving #1 after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [7:0] data, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      $display("FAIL send_timeout: in_ready=%b required 1 (sel=%0d)", bus.in_ready, sel);
      errors++;
    end
    @(posedge clk);
    #1;
    $display("send sel=%0d data=%02h last=%b", sel, data, last);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 'x;
    bus.in_sel   = 'x;
  endtask

  task automatic pulse_release();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 3'd4;
    bus.in_data = 8'hFF;
    bus.in_last = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_mask !== 8'h00) begin
      $display("FAIL reset_state: out_valid=%b out_mask=%02h required 0/00", bus.out_valid, bus.out_mask);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (bus.out_data[i] !== 8'h00) begin
        $display("FAIL reset_data[%0d]: got %02h required 00", i, bus.out_data[i]);
        errors++;
      end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
      errors++;
    end
    $display("test_reset done");
  endtask

  task automatic test_full_fill();
    for (int i = 0; i < N_OUT; i++) begin
      logic [2:0] s;
      s = 3'(i);
      if (i == N_OUT - 1) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          $display("FAIL fill_early_valid: out_valid=%b required 0 before 8th word", bus.out_valid);
          errors++;
        end
      end
      send(s, 8'h10 + 8'(i), 1'b0);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mask !== 8'hFF || bus.in_ready !== 1'b0) begin
      $display("FAIL fill_frame: valid=%b mask=%02h in_ready=%b required 1/FF/0",
               bus.out_valid, bus.out_mask, bus.in_ready);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (bus.out_data[i] !== 8'h10 + 8'(i)) begin
        $display("FAIL fill_data[%0d]: got %02h required %02h", i, bus.out_data[i], 8'h10 + 8'(i));
        errors++;
      end
    end
  endtask

  task automatic test_release();
    pulse_release();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_mask !== 8'h00 || bus.in_ready !== 1'b1) begin
      $display("FAIL release_state: valid=%b mask=%02h in_ready=%b required 0/00/1",
               bus.out_valid, bus.out_mask, bus.in_ready);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (bus.out_data[i] !== 8'h00) begin
        $display("FAIL release_data[%0d]: got %02h required 00", i, bus.out_data[i]);
        errors++;
      end
    end
  endtask

  task automatic test_early_close();
    send(3'd2, 8'hAA, 1'b0);
    send(3'd5, 8'h55, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mask !== 8'h24) begin
      $display("FAIL early_close: valid=%b mask=%02h required 1/24", bus.out_valid, bus.out_mask);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      logic [7:0] e;
      e = (i == 2) ? 8'hAA : (i == 5) ? 8'h55 : 8'h00;
      checks++;
      if (bus.out_data[i] !== e) begin
        $display("FAIL early_data[%0d]: got %02h required %02h", i, bus.out_data[i], e);
        errors++;
      end
    end
  endtask

  // Expects the early-close frame (mask 24, lanes 2/5) still held on entry.
  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'(c);
      bus.in_data  = (c % 2 == 0) ? 8'hF0 : 8'h0F;
      bus.in_last  = c[0];
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_mask !== 8'h24 ||
          bus.out_data[2] !== 8'hAA || bus.out_data[5] !== 8'h55 || bus.out_data[0] !== 8'h00) begin
        $display("FAIL hold_cycle%0d: valid=%b rdy=%b mask=%02h d2=%02h d5=%02h d0=%02h required 1/0/24/AA/55/00",
                 c, bus.out_valid, bus.in_ready, bus.out_mask, bus.out_data[2], bus.out_data[5], bus.out_data[0]);
        errors++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    pulse_release();
    for (int i = N_OUT - 1; i >= 0; i--) begin
      exp_data[i] = 8'($urandom_range(0, 255));
      send(3'(i), exp_data[i], 1'b0);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mask !== 8'hFF) begin
      $display("FAIL reverse_frame: valid=%b mask=%02h required 1/FF", bus.out_valid, bus.out_mask);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (bus.out_data[i] !== exp_data[i]) begin
        $display("FAIL reverse_data[%0d]: got %02h required %02h", i, bus.out_data[i], exp_data[i]);
        errors++;
      end
    end
    pulse_release();
  endtask

  task automatic test_overwrite();
    logic [7:0] e3;
`ifdef PE_SCATTER_COLLIDE_EN
    e3 = 8'h11;
`else
    e3 = 8'h22;
`endif
    send(3'd3, 8'h11, 1'b0);
    send(3'd3, 8'h22, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mask !== 8'h08 || bus.out_data[3] !== e3) begin
      $display("FAIL overwrite: valid=%b mask=%02h d3=%02h required 1/08/%02h",
               bus.out_valid, bus.out_mask, bus.out_data[3], e3);
      errors++;
    end
`ifdef PE_SCATTER_COLLIDE_EN
    checks++;
    if (collide !== 1'b1) begin
      $display("FAIL collide_set: got %b required 1", collide);
      errors++;
    end
`endif
    pulse_release();
`ifdef PE_SCATTER_COLLIDE_EN
    checks++;
    if (collide !== 1'b1) begin
      $display("FAIL collide_sticky: got %b required 1", collide);
      errors++;
    end
`endif
  endtask

  task automatic test_reset_in_hold();
    for (int i = 0; i < N_OUT; i++) send(3'(i), 8'h30 + 8'(i), 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL rsthold_pre: out_valid=%b required 1", bus.out_valid);
      errors++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_mask !== 8'h00 || bus.in_ready !== 1'b1) begin
      $display("FAIL rsthold_state: valid=%b mask=%02h in_ready=%b required 0/00/1",
               bus.out_valid, bus.out_mask, bus.in_ready);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (bus.out_data[i] !== 8'h00) begin
        $display("FAIL rsthold_data[%0d]: got %02h required 00", i, bus.out_data[i]);
        errors++;
      end
    end
`ifdef PE_SCATTER_COLLIDE_EN
    checks++;
    if (collide !== 1'b0) begin
      $display("FAIL collide_reset: got %b required 0", collide);
      errors++;
    end
`endif
    for (int i = 0; i < N_OUT; i++) send(3'(i), 8'h40 + 8'(i), 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mask !== 8'hFF) begin
      $display("FAIL refill_frame: valid=%b mask=%02h required 1/FF", bus.out_valid, bus.out_mask);
      errors++;
    end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (bus.out_data[i] !== 8'h40 + 8'(i)) begin
        $display("FAIL refill_data[%0d]: got %02h required %02h", i, bus.out_data[i], 8'h40 + 8'(i));
        errors++;
      end
    end
    pulse_release();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_fill();
    test_release();
    test_early_close();
    test_backpressure();
    test_overwrite();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
